// File: rtl/puzzle_pkg.sv
// Shared types and constants for the puzzle input path: move directions,
// arrow scan codes and the direction-to-control-bus one-hot mapping.
package puzzle_pkg;

    typedef enum logic [1:0] {
        MV_UP    = 2'd0,
        MV_DOWN  = 2'd1,
        MV_LEFT  = 2'd2,
        MV_RIGHT = 2'd3
    } move_dir_t;

    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;

    // Bit order {up,down,left,right} matches drawPuzzle's control bus.
    function automatic logic [3:0] dir_onehot(input move_dir_t dir);
        logic [3:0] oh;
        case (dir)
            MV_UP:    oh = 4'b1000;
            MV_DOWN:  oh = 4'b0100;
            MV_LEFT:  oh = 4'b0010;
            MV_RIGHT: oh = 4'b0001;
            default:  oh = 4'b0000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/move_fifo.sv
// First-word-fall-through queue of move directions. The head is read
// combinationally from storage; a push into a full queue only lands with a pop.
import puzzle_pkg::*;

module move_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  move_dir_t                  din,
    input  logic                       pop,
    output move_dir_t                  dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    move_dir_t            mem_r [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_r;
    logic [PTR_W-1:0]     rd_ptr_r;
    logic [CNT_W-1:0]     count_r;
    logic                 wr_en_s;
    logic                 rd_en_s;

    assign empty   = (count_r == CNT_W'(0));
    assign full    = (count_r == CNT_W'(DEPTH));
    assign rd_en_s = pop && !empty;
    assign wr_en_s = push && (!full || rd_en_s);
    assign count   = count_r;
    // Empty head reads as MV_UP so the outputs are defined after reset.
    assign dout    = empty ? MV_UP : mem_r[rd_ptr_r];

    // Storage write; contents need no reset because the head is gated by empty.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_r <= PTR_W'(0);
            rd_ptr_r <= PTR_W'(0);
            count_r  <= CNT_W'(0);
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (rd_en_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({wr_en_s, rd_en_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/arrow_key_decoder.sv
// Turns the keyboard driver's make/break stream into one move per arrow press,
// suppressing typematic repeat, and queues moves for the puzzle engine.
import puzzle_pkg::*;

module arrow_key_decoder #(
    parameter int         DEPTH      = 4,
    parameter logic [7:0] CODE_UP    = SC_UP,
    parameter logic [7:0] CODE_DOWN  = SC_DOWN,
    parameter logic [7:0] CODE_LEFT  = SC_LEFT,
    parameter logic [7:0] CODE_RIGHT = SC_RIGHT
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       valid,
    input  logic                       makeBreak,
    input  logic [7:0]                 outCode,
    output logic                       move_valid,
    output logic [1:0]                 move_dir,
    output logic [3:0]                 move_onehot,
    input  logic                       move_ready,
    output logic [3:0]                 held,
    output logic                       overflow,
    output logic [$clog2(DEPTH):0]     depth_cnt
);

    logic       valid_q_r;
    logic [3:0] held_r;
    logic       overflow_r;
    logic       event_s;
    logic       hit_s;
    move_dir_t  key_dir_s;
    logic [3:0] key_mask_s;
    logic       push_req_s;
    logic       pop_s;
    logic       full_s;
    logic       empty_s;
    move_dir_t  head_s;

    // A long valid pulse yields a single event on its rising edge.
    assign event_s = valid && !valid_q_r;

    // Classify the scan code; anything that is not an arrow is ignored.
    always_comb begin
        hit_s     = 1'b0;
        key_dir_s = MV_UP;
        if (outCode == CODE_UP) begin
            hit_s     = 1'b1;
            key_dir_s = MV_UP;
        end else if (outCode == CODE_DOWN) begin
            hit_s     = 1'b1;
            key_dir_s = MV_DOWN;
        end else if (outCode == CODE_LEFT) begin
            hit_s     = 1'b1;
            key_dir_s = MV_LEFT;
        end else if (outCode == CODE_RIGHT) begin
            hit_s     = 1'b1;
            key_dir_s = MV_RIGHT;
        end else begin
            hit_s     = 1'b0;
            key_dir_s = MV_UP;
        end
    end

    assign key_mask_s = hit_s ? dir_onehot(key_dir_s) : 4'b0000;
    // A make for an already-held key is typematic repeat and pushes nothing.
    assign push_req_s = event_s && makeBreak && hit_s && ((held_r & key_mask_s) == 4'b0000);
    assign pop_s      = !empty_s && move_ready;

    // Edge-detect history, held-key mask and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q_r  <= 1'b0;
            held_r     <= 4'b0000;
            overflow_r <= 1'b0;
        end else begin
            valid_q_r <= valid;
            if (event_s && hit_s) begin
                held_r <= makeBreak ? (held_r | key_mask_s) : (held_r & ~key_mask_s);
            end else begin
                held_r <= held_r;
            end
            if (push_req_s && full_s && !pop_s) begin
                overflow_r <= 1'b1;
            end else begin
                overflow_r <= overflow_r;
            end
        end
    end

    move_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_req_s),
        .din   (key_dir_s),
        .pop   (pop_s),
        .dout  (head_s),
        .full  (full_s),
        .empty (empty_s),
        .count (depth_cnt)
    );

    assign move_valid  = !empty_s;
    assign move_dir    = head_s;
    assign move_onehot = move_valid ? dir_onehot(head_s) : 4'b0000;
    assign held        = held_r;
    assign overflow    = overflow_r;

endmodule

// File: tb/tb_arrow_key_decoder.sv
// Randomised and directed bench for arrow_key_decoder: a queue-based reference
// model feeds a scoreboard that a negedge monitor drains on each handshake.
module tb_arrow_key_decoder;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       valid;
    logic       makeBreak;
    logic [7:0] outCode;
    logic       move_valid;
    logic [1:0] move_dir;
    logic [3:0] move_onehot;
    logic       move_ready;
    logic [3:0] held;
    logic       overflow;
    logic [2:0] depth_cnt;

    int n_vec = 0;
    int n_err = 0;
    int pop_count = 0;
    bit started = 1'b0;

    int   mq[$];
    int   exp_q[$];
    logic m_vq;
    logic [3:0] m_held;
    logic m_ovf;

    arrow_key_decoder #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .valid       (valid),
        .makeBreak   (makeBreak),
        .outCode     (outCode),
        .move_valid  (move_valid),
        .move_dir    (move_dir),
        .move_onehot (move_onehot),
        .move_ready  (move_ready),
        .held        (held),
        .overflow    (overflow),
        .depth_cnt   (depth_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int code_dir(input logic [7:0] c);
        case (c)
            8'h75:   return 0;
            8'h72:   return 1;
            8'h6B:   return 2;
            8'h74:   return 3;
            default: return -1;
        endcase
    endfunction

    // Reference model: one press event per rising valid, queue capped at DEPTH.
    always @(posedge clk) begin
        int d;
        int tmp;
        bit ev;
        started = 1'b1;
        if (!reset) begin
            m_vq   = 1'b0;
            m_held = 4'b0000;
            m_ovf  = 1'b0;
            mq.delete();
            exp_q.delete();
        end else begin
            ev   = valid && !m_vq;
            m_vq = valid;
            if (mq.size() != 0 && move_ready) tmp = mq.pop_front();
            d = code_dir(outCode);
            if (ev && d >= 0) begin
                if (makeBreak) begin
                    if (!m_held[3-d]) begin
                        m_held[3-d] = 1'b1;
                        if (mq.size() < DEPTH) begin
                            mq.push_back(d);
                            exp_q.push_back(d);
                        end else begin
                            m_ovf = 1'b1;
                        end
                    end
                end else begin
                    m_held[3-d] = 1'b0;
                end
            end
        end
    end

    // Monitor: compare presented head with scoreboard, consume on handshake.
    always @(negedge clk) begin
        int e;
        if (started) begin
            chk("depth_cnt", 8'(depth_cnt), 8'(mq.size()));
            chk("held", 8'(held), 8'(m_held));
            chk("overflow", 8'(overflow), 8'(m_ovf));
            chk("move_valid", 8'(move_valid), 8'(mq.size() != 0));
            if (move_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_move", 8'(move_valid), 8'd0);
                end else begin
                    e = exp_q[0];
                    chk("move_dir", 8'(move_dir), 8'(e));
                    chk("move_onehot", 8'(move_onehot), 8'(4'b1000 >> e));
                    if (move_ready) begin
                        e = exp_q.pop_front();
                        pop_count++;
                    end
                end
            end else begin
                chk("onehot_idle", 8'(move_onehot), 8'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [7:0] c, input logic mk, input int w);
        valid = 1'b1; makeBreak = mk; outCode = c;
        repeat (w) tick();
        valid = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        valid = 1'b0;
        reset = 1'b0;
        tick(); tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic drain();
        move_ready = 1'b1;
        for (int i = 0; i < 20 && move_valid; i++) tick();
        chk("drain_timeout", 8'(move_valid), 8'd0);
        move_ready = 1'b0;
    endtask

    initial begin
        logic [7:0] codes [6];
        int base;
        codes[0] = 8'h75; codes[1] = 8'h72; codes[2] = 8'h6B;
        codes[3] = 8'h74; codes[4] = 8'h1C; codes[5] = 8'h00;
        reset = 1'b0; valid = 1'b0; makeBreak = 1'b0; outCode = 8'h00; move_ready = 1'b0;

        // Reset state and first press latency
        do_reset();
        chk("rst_depth", 8'(depth_cnt), 8'd0);
        chk("rst_held", 8'(held), 8'd0);
        chk("rst_valid", 8'(move_valid), 8'd0);
        valid = 1'b1; makeBreak = 1'b1; outCode = 8'h75;
        tick();
        chk("t1_valid", 8'(move_valid), 8'd1);
        chk("t1_dir", 8'(move_dir), 8'd0);
        chk("t1_onehot", 8'(move_onehot), 8'h08);
        chk("t1_held", 8'(held), 8'h08);
        valid = 1'b0;
        tick();

        // Typematic suppression
        do_reset();
        move_ready = 1'b1;
        base = pop_count;
        repeat (5) press(8'h75, 1'b1, 1);
        chk("t2_one_pop", 8'(pop_count - base), 8'd1);
        press(8'h75, 1'b0, 1);
        chk("t2_held", 8'(held), 8'd0);
        press(8'h75, 1'b1, 1);
        tick();
        chk("t2_two_pops", 8'(pop_count - base), 8'd2);

        // Long valid pulse
        do_reset();
        move_ready = 1'b0;
        valid = 1'b1; makeBreak = 1'b1; outCode = 8'h6B;
        repeat (10) tick();
        chk("t3_depth", 8'(depth_cnt), 8'd1);
        chk("t3_dir", 8'(move_dir), 8'd2);
        valid = 1'b0;
        tick();
        drain();

        // Full queue with simultaneous push and pop
        do_reset();
        for (int i = 0; i < 4; i++) press(codes[i], 1'b1, 1);
        for (int i = 0; i < 4; i++) press(codes[i], 1'b0, 1);
        chk("t4_full", 8'(depth_cnt), 8'd4);
        valid = 1'b1; makeBreak = 1'b1; outCode = 8'h75; move_ready = 1'b1;
        tick();
        valid = 1'b0; move_ready = 1'b0;
        tick();
        chk("t4_depth", 8'(depth_cnt), 8'd4);
        chk("t4_ovf", 8'(overflow), 8'd0);
        chk("t4_head", 8'(move_dir), 8'd1);
        drain();

        // Overflow
        do_reset();
        for (int i = 0; i < 4; i++) press(codes[i], 1'b1, 1);
        for (int i = 0; i < 4; i++) press(codes[i], 1'b0, 1);
        press(8'h75, 1'b1, 1);
        press(8'h74, 1'b1, 1);
        chk("t5_depth", 8'(depth_cnt), 8'd4);
        chk("t5_ovf", 8'(overflow), 8'd1);
        drain();
        chk("t5_ovf_sticky", 8'(overflow), 8'd1);

        // Non-arrow codes, then reset with entries queued
        do_reset();
        for (int i = 0; i < 3; i++) press(codes[i], 1'b1, 1);
        press(8'h1C, 1'b1, 2);
        press(8'h1C, 1'b0, 1);
        chk("t6_depth", 8'(depth_cnt), 8'd3);
        chk("t6_held", 8'(held), 8'h0E);
        reset = 1'b0;
        tick();
        chk("t6_rst_depth", 8'(depth_cnt), 8'd0);
        chk("t6_rst_valid", 8'(move_valid), 8'd0);
        chk("t6_rst_held", 8'(held), 8'd0);
        reset = 1'b1;
        tick();

        // Randomised traffic
        for (int n = 0; n < 400; n++) begin
            move_ready = ($urandom_range(0, 3) != 0) ? 1'b0 : 1'b1;
            if ($urandom_range(0, 60) == 0) begin
                reset = 1'b0;
                tick();
                reset = 1'b1;
            end
            press(codes[$urandom_range(0, 5)], 1'($urandom_range(0, 1)), $urandom_range(1, 3));
        end
        drain();
        chk("sb_empty", 8'(exp_q.size()), 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
